keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad, debounces presses, and produces one hex key code per physical press plus a 4-digit entry register. It is the input side of the combo lock: the 16-bit `digits` output feeds the seven-segment driver's four digit inputs directly, and `key_valid`/`key_code` feed the lock FSM. Row strobing uses the same slow-tick multiplexing scheme as the display side.

---
 rtl/keypad_pkg.sv | 44 ++++
 rtl/keypad_scanner_sync_2ff.sv | 28 ++
 rtl/keypad_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_scanner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM states, idle/reset
// patterns and the matrix position to hex code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // First row strobed after reset; rows rotate left from here.
    localparam logic [3:0] ROW_RESET = 4'b1110;

    // Column pattern with no key pulling any column low.
    localparam logic [3:0] COL_IDLE  = 4'b1111;

    // Map of (row, column) to the printed key value.
    // The '*' key reports E and the '#' key reports F.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for the four keypad column lines. Resets to the
// idle (all pulled-up) pattern so no phantom key is seen after reset.
module sync_2ff
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_reg;
    logic [3:0] sync_reg;

    // Capture the asynchronous columns, then re-register to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= COL_IDLE;
            sync_reg <= COL_IDLE;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes rows on a slow tick, debounces a
// single-key press and its release, emits one key code per press and keeps
// the last four codes in a shift register for the display.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_N   = 20,
    parameter int DB_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col_n,
    input  logic        clear,
    output logic [3:0]  row_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] digits
);

    localparam int CNT_W = $clog2(DB_TICKS + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_TICKS);

    logic [3:0]        col_s;
    logic [SCAN_N-1:0] scan_cnt_reg;
    logic              tick;

    state_t            state_reg;
    logic [3:0]        row_n_reg;
    logic              key_valid_reg;
    logic [3:0]        key_code_reg;
    logic [15:0]       digits_reg;
    logic [CNT_W-1:0]  db_cnt_reg;
    logic [3:0]        lat_pat_reg;
    logic [3:0]        lat_code_reg;

    logic [3:0]        col_low;
    logic              single_low;
    logic [1:0]        col_idx;
    logic [1:0]        row_idx;
    logic [3:0]        row_rot;
    logic [CNT_W-1:0]  db_inc;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (col_n),
        .q   (col_s)
    );

    // Free-running scan divider; the all-ones cycle is the scan tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_reg <= '0;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
    end

    assign tick = &scan_cnt_reg;

    // Decode the synchronized columns and current row into matrix indices.
    always_comb begin
        col_low    = ~col_s;
        single_low = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);
        col_idx    = 2'd0;
        row_idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (col_low[i]) col_idx = i[1:0];
            if (!row_n_reg[i]) row_idx = i[1:0];
        end
    end

    assign row_rot = {row_n_reg[2:0], row_n_reg[3]};
    assign db_inc  = db_cnt_reg + 1'b1;

    // Scan / debounce / hold FSM with registered outputs; clear overrides the digit shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= SCAN;
            row_n_reg     <= ROW_RESET;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'h0;
            digits_reg    <= 16'h0000;
            db_cnt_reg    <= '0;
            lat_pat_reg   <= COL_IDLE;
            lat_code_reg  <= 4'h0;
        end else begin
            key_valid_reg <= 1'b0;
            if (tick) begin
                case (state_reg)
                    SCAN: begin
                        if (single_low) begin
                            lat_pat_reg  <= col_s;
                            lat_code_reg <= key_map(row_idx, col_idx);
                            db_cnt_reg   <= '0;
                            state_reg    <= DEBOUNCE;
                        end else begin
                            row_n_reg <= row_rot;
                        end
                    end
                    DEBOUNCE: begin
                        if (col_s == lat_pat_reg) begin
                            if (db_inc == DB_LAST) begin
                                key_code_reg  <= lat_code_reg;
                                key_valid_reg <= 1'b1;
                                digits_reg    <= {digits_reg[11:0], lat_code_reg};
                                db_cnt_reg    <= '0;
                                state_reg     <= HELD;
                            end else begin
                                db_cnt_reg <= db_inc;
                            end
                        end else begin
                            state_reg <= SCAN;
                            row_n_reg <= row_rot;
                        end
                    end
                    HELD: begin
                        if (col_s == COL_IDLE) begin
                            if (db_inc == DB_LAST) begin
                                db_cnt_reg <= '0;
                                state_reg  <= SCAN;
                                row_n_reg  <= row_rot;
                            end else begin
                                db_cnt_reg <= db_inc;
                            end
                        end else begin
                            db_cnt_reg <= '0;
                        end
                    end
                    default: begin
                        state_reg <= SCAN;
                    end
                endcase
            end
            if (clear) begin
                digits_reg <= 16'h0000;
            end
        end
    end

    assign row_n     = row_n_reg;
    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign digits    = digits_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 matrix model.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_n;
    logic        clear = 1'b0;
    logic [3:0]  row_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] digits;

    logic [15:0] press = 16'h0000;   // bit r*4+c = key at row r, column c closed
    int          total = 0;
    int          bad   = 0;
    int          vcount = 0;

    typedef struct {
        int          r;
        int          c;
        logic [3:0]  code;
        logic [15:0] digs;
    } vec_t;

    vec_t tbl [11];

    keypad_scanner #(.SCAN_N(2), .DB_TICKS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .clear     (clear),
        .row_n     (row_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .digits    (digits)
    );

    always #5 clk = ~clk;

    // Matrix model: a closed key pulls its column low while its row is strobed.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    // Count every cycle key_valid is high.
    always @(negedge clk) begin
        if (key_valid === 1'b1) vcount = vcount + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick_n(3);
        rst = 1'b0;
    endtask

    // Return at the first negedge after row_n switches to target.
    task automatic wait_row_enter(input logic [3:0] target);
        int n;
        n = 0;
        while (row_n == target && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (row_n != target && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL wait_row timeout: got %0h want %0h", row_n, target);
        end
    endtask

    task automatic press_release(input int r, input int c, input int hold);
        press[r*4+c] = 1'b1;
        tick_n(hold);
        press = 16'h0000;
        tick_n(30);
    endtask

    initial begin
        int vbase;
        int chg;
        logic [3:0] prev;

        tbl[0]  = '{0, 0, 4'h1, 16'h0001};
        tbl[1]  = '{0, 1, 4'h2, 16'h0012};
        tbl[2]  = '{0, 2, 4'h3, 16'h0123};
        tbl[3]  = '{1, 0, 4'h4, 16'h1234};
        tbl[4]  = '{2, 0, 4'h7, 16'h2347};
        tbl[5]  = '{3, 0, 4'hE, 16'h347E};
        tbl[6]  = '{3, 2, 4'hF, 16'h47EF};
        tbl[7]  = '{3, 1, 4'h0, 16'h7EF0};
        tbl[8]  = '{3, 3, 4'hD, 16'hEF0D};
        tbl[9]  = '{1, 3, 4'hB, 16'hF0DB};
        tbl[10] = '{2, 3, 4'hC, 16'h0DBC};

        // Reset values
        tick_n(3);
        check("reset_row_n", row_n, 4'b1110);
        check("reset_key_valid", key_valid, 1'b0);
        check("reset_key_code", key_code, 4'h0);
        check("reset_digits", digits, 16'h0000);

        // Clean press of "5" from a known phase right after reset
        vbase = vcount;
        press[5] = 1'b1;
        rst = 1'b0;
        tick_n(19);
        check("clean_valid_before", key_valid, 1'b0);
        tick_n(1);
        check("clean_valid_pulse", key_valid, 1'b1);
        check("clean_code", key_code, 4'h5);
        check("clean_digits", digits, 16'h0005);
        tick_n(1);
        check("clean_valid_one_cycle", key_valid, 1'b0);
        tick_n(19);
        check("clean_row_frozen_held", row_n, 4'b1101);
        press = 16'h0000;
        tick_n(6);
        check("clean_row_frozen_release", row_n, 4'b1101);
        tick_n(8);
        check("clean_row_rotated", row_n, 4'b1011);
        tick_n(20);
        check("clean_pulse_count", vcount - vbase, 1);

        // Bounce on "9": brief first contact must abort the debounce
        do_reset();
        vbase = vcount;
        press[10] = 1'b1;
        tick_n(13);
        check("bounce_row_latched", row_n, 4'b1011);
        press = 16'h0000;
        tick_n(4);
        check("bounce_aborted_row", row_n, 4'b0111);
        check("bounce_no_pulse", vcount - vbase, 0);
        press_release(2, 2, 60);
        check("bounce_pulse_count", vcount - vbase, 1);
        check("bounce_code", key_code, 4'h9);
        check("bounce_digits", digits, 16'h0009);

        // Entry sequence table
        do_reset();
        for (int i = 0; i < 11; i++) begin
            vbase = vcount;
            press_release(tbl[i].r, tbl[i].c, 50);
            check($sformatf("entry%0d_pulses", i), vcount - vbase, 1);
            check($sformatf("entry%0d_code", i), key_code, tbl[i].code);
            check($sformatf("entry%0d_digits", i), digits, tbl[i].digs);
        end

        // Two columns low on one row: no press, rows keep rotating
        vbase = vcount;
        press[4] = 1'b1;
        press[5] = 1'b1;
        chg  = 0;
        prev = row_n;
        repeat (40) begin
            @(negedge clk);
            if (row_n != prev) chg++;
            prev = row_n;
        end
        check("multi_rotations", chg, 10);
        press = 16'h0000;
        tick_n(30);
        check("multi_no_pulse", vcount - vbase, 0);

        // Long hold of "A": one pulse only
        vbase = vcount;
        press_release(0, 3, 100);
        check("hold_pulse_count", vcount - vbase, 1);
        check("hold_code", key_code, 4'hA);
        check("hold_digits", digits, 16'hDBCA);

        // Clear coinciding with the commit of "8"
        vbase = vcount;
        wait_row_enter(4'b1011);
        press[9] = 1'b1;
        tick_n(15);
        clear = 1'b1;
        tick_n(1);
        clear = 1'b0;
        check("clear_valid", key_valid, 1'b1);
        check("clear_code", key_code, 4'h8);
        check("clear_digits", digits, 16'h0000);
        tick_n(10);
        press = 16'h0000;
        tick_n(30);
        check("clear_pulse_count", vcount - vbase, 1);

        // Asynchronous reset in the middle of a debounce, key kept held
        press_release(1, 2, 50);
        check("prereset_digits", digits, 16'h0006);
        wait_row_enter(4'b1101);
        press[5] = 1'b1;
        tick_n(8);
        check("midreset_row_frozen", row_n, 4'b1101);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_row_n", row_n, 4'b1110);
        check("midreset_digits", digits, 16'h0000);
        check("midreset_key_valid", key_valid, 1'b0);
        check("midreset_key_code", key_code, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        vbase = vcount;
        tick_n(40);
        press = 16'h0000;
        tick_n(30);
        check("redetect_pulse_count", vcount - vbase, 1);
        check("redetect_code", key_code, 4'h5);
        check("redetect_digits", digits, 16'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
